tiny_alu_gen2: RTL and testbench

Parametrised successor of the tiny ALU datapath. It takes two DATA_W-bit operands plus an opcode on a start/ready handshake. Single-cycle ops (ADD/AND/XOR) run at full throughput. MUL is multi-cycle with configurable latency and an optional signed mode. Illegal opcodes are flagged with an error pulse. It sits behind the tiny_alu interface as the ALU execution core.

---
 rtl/tiny_alu_gen2_pkg.sv | 25 ++
 rtl/tiny_alu_gen2_if.sv | 33 +++
 rtl/tiny_alu_gen2_mul.sv | 78 +++++++
 rtl/tiny_alu_gen2.sv | 163 ++++++++++++++++
 tb/tb_tiny_alu_gen2.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tiny_alu_gen2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tiny_alu_pkg
// Description : Shared opcode encoding and helpers for the tiny ALU core.
// Revision    : 1.0 - initial release
// ============================================================================
package tiny_alu_pkg;

    localparam int OPCODE_BITS = 3;

    typedef enum logic [OPCODE_BITS-1:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } opcode_e;

    // Encodings above MUL are reserved and reported as errors.
    function automatic logic is_legal_op(input logic [OPCODE_BITS-1:0] i_op);
        return (i_op <= OP_MUL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tiny_alu_gen2_if.sv
`default_nettype none
// ============================================================================
// Module      : tiny_alu_gen2_if
// Description : Request/response bundle between a requester and the ALU core.
// Revision    : 1.0 - initial release
// ============================================================================
interface tiny_alu_gen2_if #(
    parameter int DATA_W = 8
);
    import tiny_alu_pkg::*;

    logic [DATA_W-1:0]      a_i;
    logic [DATA_W-1:0]      b_i;
    logic [OPCODE_BITS-1:0] opcode_i;
    logic                   signed_i;
    logic                   start_i;
    logic                   ready_o;
    logic [2*DATA_W-1:0]    result_o;
    logic                   done_o;
    logic                   err_o;

    modport master (
        output a_i, b_i, opcode_i, signed_i, start_i,
        input  ready_o, result_o, done_o, err_o
    );

    modport slave (
        input  a_i, b_i, opcode_i, signed_i, start_i,
        output ready_o, result_o, done_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/tiny_alu_gen2_mul.sv
`default_nettype none
// ============================================================================
// Module      : tiny_alu_mul
// Description : DATA_W x DATA_W signed/unsigned multiplier with captured
//               operands. The product is valid by the time the parent's
//               latency counter expires.
// Revision    : 1.0 - initial release
// ============================================================================
module tiny_alu_mul
    import tiny_alu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MUL_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_signed,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    output logic [2*DATA_W-1:0] o_product
);

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic                r_signed;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic                w_signed;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_full;

    // Hold the operands of the accepted MUL for the whole busy window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
        end else if (i_en) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_signed <= i_signed;
        end
    end

    // Live operands in the accept cycle so a single-cycle MUL sees them.
    always_comb begin
        w_a      = i_en ? i_a      : r_a;
        w_b      = i_en ? i_b      : r_b;
        w_signed = i_en ? i_signed : r_signed;
        w_a_ext  = w_signed ? {{DATA_W{w_a[DATA_W-1]}}, w_a} : {{DATA_W{1'b0}}, w_a};
        w_b_ext  = w_signed ? {{DATA_W{w_b[DATA_W-1]}}, w_b} : {{DATA_W{1'b0}}, w_b};
        // Low 2*DATA_W bits of the extended product are exact for both modes.
        w_full   = w_a_ext * w_b_ext;
    end

    generate
        if (MUL_CYCLES >= 3) begin : g_prod_reg
            logic [2*DATA_W-1:0] r_prod;

            // Extra pipeline stage; settled one edge after capture.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prod <= '0;
                end else begin
                    r_prod <= w_full;
                end
            end

            assign o_product = r_prod;
        end else begin : g_prod_comb
            assign o_product = w_full;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tiny_alu_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tiny_alu_gen2
// Description : ALU execution core. ADD/AND/XOR complete in one cycle at full
//               throughput; MUL takes MUL_CYCLES cycles; reserved opcodes
//               return an error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tiny_alu_gen2
    import tiny_alu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MUL_CYCLES = 3
) (
    input  logic           clk_i,
    input  logic           reset_i,
    tiny_alu_gen2_if.slave bus
);

    localparam int c_CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MUL_CYCLES - 1);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_MUL_BUSY = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                w_ready;
    logic                w_accept;
    logic                w_mul_start;
    logic                w_mul_done;
    opcode_e             w_op;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_sum;
    logic [2*DATA_W-1:0] w_product;
    logic [2*DATA_W-1:0] r_result;
    logic                r_done;
    logic                r_err;

    assign w_op        = opcode_e'(bus.opcode_i);
    assign w_accept    = bus.start_i && w_ready;
    assign w_mul_start = w_accept && (w_op == OP_MUL);
    // Counter hits zero on this edge: the product is captured now.
    assign w_mul_done  = (r_state == c_MUL_BUSY) && (r_cnt == c_CNT_W'(1));

    // Operand extension for ADD; zero-extension when unsigned.
    always_comb begin
        w_a_ext = bus.signed_i ? {{DATA_W{bus.a_i[DATA_W-1]}}, bus.a_i}
                               : {{DATA_W{1'b0}}, bus.a_i};
        w_b_ext = bus.signed_i ? {{DATA_W{bus.b_i[DATA_W-1]}}, bus.b_i}
                               : {{DATA_W{1'b0}}, bus.b_i};
        w_sum   = w_a_ext + w_b_ext;
    end

    tiny_alu_mul #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk_i),
        .rst       (reset_i),
        .i_en      (w_mul_start),
        .i_signed  (bus.signed_i),
        .i_a       (bus.a_i),
        .i_b       (bus.b_i),
        .o_product (w_product)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: only a multi-cycle MUL leaves IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_mul_start && (MUL_CYCLES > 1)) begin
                    w_state_nxt = c_MUL_BUSY;
                end
            end
            c_MUL_BUSY: begin
                if (w_mul_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs: accept only in IDLE and never while reset is held.
    always_comb begin
        w_ready = (r_state == c_IDLE) && !reset_i;
    end

    // MUL latency counter; loaded on accept, counts down to zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (w_mul_start && (r_state == c_IDLE)) begin
            r_cnt <= c_CNT_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    // Result and single-cycle done/err pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_mul_done) begin
                r_result <= w_product;
                r_done   <= 1'b1;
            end else if (w_accept) begin
                if (!is_legal_op(bus.opcode_i)) begin
                    r_result <= '0;
                    r_done   <= 1'b1;
                    r_err    <= 1'b1;
                end else begin
                    case (w_op)
                        OP_ADD: begin
                            r_result <= w_sum;
                            r_done   <= 1'b1;
                        end
                        OP_AND: begin
                            r_result <= {{DATA_W{1'b0}}, bus.a_i & bus.b_i};
                            r_done   <= 1'b1;
                        end
                        OP_XOR: begin
                            r_result <= {{DATA_W{1'b0}}, bus.a_i ^ bus.b_i};
                            r_done   <= 1'b1;
                        end
                        OP_MUL: begin
                            if (MUL_CYCLES == 1) begin
                                r_result <= w_product;
                                r_done   <= 1'b1;
                            end
                        end
                        default: ; // NOP leaves the result untouched
                    endcase
                end
            end
        end
    end

    assign bus.ready_o  = w_ready;
    assign bus.result_o = r_result;
    assign bus.done_o   = r_done;
    assign bus.err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tiny_alu_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tb_tiny_alu_gen2
// Description : Directed bench for tiny_alu_gen2 in two configurations
//               (8-bit / 3-cycle MUL and 16-bit / 1-cycle MUL).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tiny_alu_gen2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    tiny_alu_gen2_if #(.DATA_W(8))  if8 ();
    tiny_alu_gen2_if #(.DATA_W(16)) if16 ();

    tiny_alu_gen2 #(.DATA_W(8), .MUL_CYCLES(3)) u_dut8 (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (if8)
    );

    tiny_alu_gen2 #(.DATA_W(16), .MUL_CYCLES(1)) u_dut16 (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (if16)
    );

    // ------------------------------------------------------------------
    // Reference model: arithmetic on plain integers, latency by schedule
    // ------------------------------------------------------------------
    longint m_res  [2];
    longint m_pend [2];
    bit     m_done [2];
    bit     m_err  [2];
    int     m_busy [2];
    int     c_w    [2] = '{8, 16};
    int     c_mc   [2] = '{3, 1};

    function automatic void model_op(input int w, input int op, input longint a,
                                     input longint b, input bit sg,
                                     output longint res, output bit upd, output bit er);
        longint mask2 = (longint'(1) << (2 * w)) - 1;
        longint sa = a;
        longint sb = b;
        if (sg && a >= (longint'(1) << (w - 1))) sa = a - (longint'(1) << w);
        if (sg && b >= (longint'(1) << (w - 1))) sb = b - (longint'(1) << w);
        res = 0; upd = 1; er = 0;
        case (op)
            0:       upd = 0;
            1:       res = (sa + sb) & mask2;
            2:       res = a & b;
            3:       res = a ^ b;
            4:       res = (sa * sb) & mask2;
            default: er  = 1;
        endcase
    endfunction

    always @(posedge clk) begin
        longint in_a [2];
        longint in_b [2];
        int     in_op[2];
        bit     in_sg[2];
        bit     in_st[2];
        longint r;
        bit     upd;
        bit     er;
        in_a[0] = longint'(if8.a_i);   in_b[0] = longint'(if8.b_i);
        in_op[0] = int'(if8.opcode_i); in_sg[0] = if8.signed_i;  in_st[0] = if8.start_i;
        in_a[1] = longint'(if16.a_i);  in_b[1] = longint'(if16.b_i);
        in_op[1] = int'(if16.opcode_i); in_sg[1] = if16.signed_i; in_st[1] = if16.start_i;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_res[k] = 0; m_done[k] = 0; m_err[k] = 0; m_busy[k] = 0;
            end else begin
                m_done[k] = 0;
                m_err[k]  = 0;
                if (m_busy[k] > 0) begin
                    m_busy[k]--;
                    if (m_busy[k] == 0) begin
                        m_res[k]  = m_pend[k];
                        m_done[k] = 1;
                    end
                end else if (in_st[k]) begin
                    model_op(c_w[k], in_op[k], in_a[k], in_b[k], in_sg[k], r, upd, er);
                    if (in_op[k] == 4 && c_mc[k] > 1) begin
                        m_pend[k] = r;
                        m_busy[k] = c_mc[k] - 1;
                    end else if (upd) begin
                        m_res[k]  = r;
                        m_done[k] = 1;
                        m_err[k]  = er;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(posedge clk);
            #3;
            chk("cyc8.ready",   if8.ready_o,   (!rst && m_busy[0] == 0));
            chk("cyc8.done",    if8.done_o,    m_done[0]);
            chk("cyc8.err",     if8.err_o,     m_err[0]);
            chk("cyc8.result",  if8.result_o,  32'(m_res[0]));
            chk("cyc16.ready",  if16.ready_o,  (!rst && m_busy[1] == 0));
            chk("cyc16.done",   if16.done_o,   m_done[1]);
            chk("cyc16.err",    if16.err_o,    m_err[1]);
            chk("cyc16.result", if16.result_o, 32'(m_res[1]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: inputs change 1 ns after the rising edge
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic sg);
        if8.opcode_i = op; if8.a_i = a; if8.b_i = b; if8.signed_i = sg;
        if8.start_i  = 1'b1;
        tick(1);
    endtask

    task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic sg);
        if16.opcode_i = op; if16.a_i = a; if16.b_i = b; if16.signed_i = sg;
        if16.start_i  = 1'b1;
        tick(1);
    endtask

    int ndone;

    initial begin
        if8.start_i  = 1'b0; if8.a_i  = '0; if8.b_i  = '0; if8.opcode_i  = '0; if8.signed_i  = 1'b0;
        if16.start_i = 1'b0; if16.a_i = '0; if16.b_i = '0; if16.opcode_i = '0; if16.signed_i = 1'b0;

        // Reset state
        tick(3);
        chk("rst.ready", if8.ready_o, 0);
        chk("rst.done",  if8.done_o,  0);
        chk("rst.result", if8.result_o, 0);
        rst = 1'b0;
        tick(1);
        chk("post_rst.ready", if8.ready_o, 1);

        // ADD unsigned / signed, then back-to-back XOR
        issue8(3'd1, 8'hFF, 8'h01, 1'b0);
        chk("add_u.done",   if8.done_o,   1);
        chk("add_u.result", if8.result_o, 32'h0100);
        chk("add_u.err",    if8.err_o,    0);
        issue8(3'd1, 8'hFF, 8'h01, 1'b1);
        chk("add_s.done",   if8.done_o,   1);
        chk("add_s.result", if8.result_o, 32'h0000);
        issue8(3'd3, 8'hF0, 8'h3C, 1'b0);
        chk("xor.done",   if8.done_o,   1);
        chk("xor.result", if8.result_o, 32'h00CC);
        if8.start_i = 1'b0;
        tick(1);
        chk("xor.done_drop", if8.done_o, 0);

        // MUL unsigned, 3-cycle latency
        issue8(3'd4, 8'hFF, 8'hFF, 1'b0);
        if8.start_i = 1'b0;
        chk("mul_u.busy1", if8.ready_o, 0);
        chk("mul_u.nodone1", if8.done_o, 0);
        tick(1);
        chk("mul_u.busy2", if8.ready_o, 0);
        chk("mul_u.nodone2", if8.done_o, 0);
        tick(1);
        chk("mul_u.done",   if8.done_o,   1);
        chk("mul_u.result", if8.result_o, 32'hFE01);
        chk("mul_u.ready",  if8.ready_o,  1);

        // MUL signed with start held through the busy window
        issue8(3'd4, 8'hFF, 8'hFF, 1'b1);
        ndone = int'(if8.done_o);
        tick(1); ndone += int'(if8.done_o);
        tick(1); ndone += int'(if8.done_o);
        if8.start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            ndone += int'(if8.done_o);
        end
        chk("mul_s.ndone",  ndone, 1);
        chk("mul_s.result", if8.result_o, 32'h0001);

        // NOP holds the previous result
        issue8(3'd0, 8'h12, 8'h34, 1'b0);
        if8.start_i = 1'b0;
        chk("nop.done",   if8.done_o,   0);
        chk("nop.result", if8.result_o, 32'h0001);
        chk("nop.ready",  if8.ready_o,  1);

        // Illegal opcode
        issue8(3'd6, 8'h55, 8'hAA, 1'b0);
        if8.start_i = 1'b0;
        chk("ill.done",   if8.done_o,   1);
        chk("ill.err",    if8.err_o,    1);
        chk("ill.result", if8.result_o, 0);
        tick(1);
        chk("ill.err_drop", if8.err_o, 0);

        // Assorted signed / mixed vectors
        issue8(3'd4, 8'h80, 8'h7F, 1'b1);
        if8.start_i = 1'b0;
        tick(2);
        chk("mul_s2.result", if8.result_o, 32'hC080);
        issue8(3'd1, 8'h80, 8'h80, 1'b1);
        chk("add_s2.result", if8.result_o, 32'hFF00);
        issue8(3'd2, 8'hA5, 8'h0F, 1'b1);
        chk("and.result", if8.result_o, 32'h0005);
        issue8(3'd1, 8'h03, 8'h04, 1'b0);
        if8.start_i = 1'b0;
        chk("add3.result", if8.result_o, 32'h0007);

        // Reset one cycle after a MUL accept aborts it
        issue8(3'd4, 8'hFF, 8'hFF, 1'b0);
        if8.start_i = 1'b0;
        rst = 1'b1;
        ndone = 0;
        tick(1); ndone += int'(if8.done_o);
        tick(1); ndone += int'(if8.done_o);
        rst = 1'b0;
        tick(1);
        chk("abort.ready", if8.ready_o, 1);
        for (int i = 0; i < 4; i++) begin
            ndone += int'(if8.done_o);
            tick(1);
        end
        chk("abort.ndone",  ndone, 0);
        chk("abort.result", if8.result_o, 0);

        // 16-bit core, single-cycle MUL
        issue16(3'd4, 16'hFFFF, 16'hFFFF, 1'b0);
        chk("mul16_u.done",   if16.done_o,   1);
        chk("mul16_u.result", if16.result_o, 32'hFFFE0001);
        chk("mul16_u.ready",  if16.ready_o,  1);
        issue16(3'd4, 16'hFFFF, 16'hFFFF, 1'b1);
        chk("mul16_s.result", if16.result_o, 32'h00000001);
        chk("mul16_s.ready",  if16.ready_o,  1);
        issue16(3'd1, 16'hFFFF, 16'h0001, 1'b0);
        if16.start_i = 1'b0;
        chk("add16.result", if16.result_o, 32'h00010000);
        tick(1);
        chk("add16.done_drop", if16.done_o, 0);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
